multicycle_core: RTL

- Parametrised multi-cycle successor of the single-cycle 18-bit datapath.
- Contains a control FSM that sequences fetch, decode, execute, memory and writeback around an internal register file, ALU, comparator and PC.
- Instruction and data memories are external and accessed over req/ack handshakes, so wait-state memories are supported.
- Adds start/halt control, condition flags, load/store and a debug register read port.

---
 rtl/multicycle_core.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_core.sv
// Multi-cycle core: an FSM sequences fetch/decode/execute/memory/writeback around a
// register file, ALU and comparator, with req/ack instruction and data memory ports.
module multicycle_core #(
    parameter int unsigned DATA_W  = 18,
    parameter int unsigned REG_CNT = 16,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [17:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              zf,
    output logic              cf,
    output logic              busy,
    output logic              halted,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalted
    } state_e;

    localparam logic [3:0] OpAnd  = 4'd0;
    localparam logic [3:0] OpAdd  = 4'd1;
    localparam logic [3:0] OpNand = 4'd2;
    localparam logic [3:0] OpNor  = 4'd3;
    localparam logic [3:0] OpAddi = 4'd4;
    localparam logic [3:0] OpAndi = 4'd5;
    localparam logic [3:0] OpLd   = 4'd6;
    localparam logic [3:0] OpSt   = 4'd7;
    localparam logic [3:0] OpJmp  = 4'd8;
    localparam logic [3:0] OpBeq  = 4'd9;
    localparam logic [3:0] OpBlt  = 4'd10;
    localparam logic [3:0] OpBgt  = 4'd11;
    localparam logic [3:0] OpHlt  = 4'd12;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [17:0]       ir_q, ir_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              zf_q, zf_d;
    logic              cf_q, cf_d;
    logic              reg_we;

    // Sixteen entries always exist; those at or above REG_CNT are never written.
    logic [DATA_W-1:0] regs_q [16];

    logic [3:0]        op, f_rd, f_rs1, f_rs2;
    logic signed [5:0] imm6_s;
    logic signed [9:0] addr10_s;
    logic [DATA_W-1:0] imm_ext;
    logic [ADDR_W-1:0] br_off, jmp_off, pc_inc;
    logic [DATA_W-1:0] rd_val, rs1_val, rs2_val;

    assign op       = ir_q[17:14];
    assign f_rd     = ir_q[13:10];
    assign f_rs1    = ir_q[9:6];
    assign f_rs2    = ir_q[3:0];
    assign imm6_s   = ir_q[5:0];
    assign addr10_s = ir_q[9:0];

    // Size casts of signed operands sign-extend (or truncate) to the target width.
    assign imm_ext = DATA_W'(imm6_s);
    assign br_off  = ADDR_W'(imm6_s);
    assign jmp_off = ADDR_W'(addr10_s);
    assign pc_inc  = pc_q + ADDR_W'(1);

    assign rd_val   = (32'(f_rd) < REG_CNT) ? regs_q[f_rd] : '0;
    assign rs1_val  = (32'(f_rs1) < REG_CNT) ? regs_q[f_rs1] : '0;
    assign rs2_val  = (32'(f_rs2) < REG_CNT) ? regs_q[f_rs2] : '0;
    assign dbg_data = (32'(dbg_sel) < REG_CNT) ? regs_q[dbg_sel] : '0;

    logic              imm_op;
    logic [DATA_W-1:0] alu_b, alu_res;
    logic [DATA_W:0]   sum;
    logic              alu_cf;

    assign imm_op = (op == OpAddi) || (op == OpAndi);

    always_comb begin
        alu_b   = imm_op ? imm_ext : rs2_val;
        sum     = {1'b0, rs1_val} + {1'b0, alu_b};
        alu_res = '0;
        alu_cf  = 1'b0;
        case (op)
            OpAnd, OpAndi: alu_res = rs1_val & alu_b;
            OpAdd, OpAddi: begin
                alu_res = sum[DATA_W-1:0];
                alu_cf  = sum[DATA_W];
            end
            OpNand:  alu_res = ~(rs1_val & alu_b);
            OpNor:   alu_res = ~(rs1_val | alu_b);
            default: alu_res = '0;
        endcase
    end

    // Unsigned compare of reg[rd] against reg[rs1].
    logic br_taken;

    always_comb begin
        br_taken = 1'b0;
        case (op)
            OpBeq:   br_taken = (rd_val == rs1_val);
            OpBlt:   br_taken = (rd_val < rs1_val);
            OpBgt:   br_taken = (rd_val > rs1_val);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        res_d   = res_q;
        zf_d    = zf_q;
        cf_d    = cf_q;
        reg_we  = 1'b0;
        case (state_q)
            StIdle, StHalted: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                case (op)
                    OpAnd, OpAdd, OpNand, OpNor, OpAddi, OpAndi: state_d = StExec;
                    OpLd, OpSt: state_d = StMem;
                    OpJmp: begin
                        pc_d    = pc_inc + jmp_off;
                        state_d = StFetch;
                    end
                    OpBeq, OpBlt, OpBgt: begin
                        pc_d    = br_taken ? (pc_inc + br_off) : pc_inc;
                        state_d = StFetch;
                    end
                    OpHlt: state_d = StHalted;
                    default: begin
                        pc_d    = pc_inc;
                        state_d = StFetch;
                    end
                endcase
            end
            StExec: begin
                res_d   = alu_res;
                zf_d    = (alu_res == '0);
                cf_d    = alu_cf;
                state_d = StWb;
            end
            StMem: begin
                if (dmem_ack) begin
                    if (op == OpSt) begin
                        pc_d    = pc_inc;
                        state_d = StFetch;
                    end else begin
                        res_d   = dmem_rdata;
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                reg_we  = 1'b1;
                pc_d    = pc_inc;
                state_d = StFetch;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ir_q    <= '0;
            res_q   <= '0;
            zf_q    <= 1'b0;
            cf_q    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            res_q   <= res_d;
            zf_q    <= zf_d;
            cf_q    <= cf_d;
            if (reg_we && (32'(f_rd) < REG_CNT)) begin
                regs_q[f_rd] <= res_q;
            end
        end
    end

    // Memory outputs derive from IR and the register file, both frozen while waiting.
    assign imem_req   = (state_q == StFetch);
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == StMem);
    assign dmem_we    = dmem_req && (op == OpSt);
    assign dmem_addr  = ADDR_W'(ir_q[9:0]);
    assign dmem_wdata = rd_val;
    assign pc         = pc_q;
    assign zf         = zf_q;
    assign cf         = cf_q;
    assign busy       = (state_q != StIdle) && (state_q != StHalted);
    assign halted     = (state_q == StHalted);

endmodule
